// File: rtl/apb_req_arbiter_if.sv
// rtl/apb_req_arbiter_if.sv - requester and APB-monitor bundle for apb_req_arbiter
// Purpose: carries the requester handshake, the command/write-data path to the
//          APB master and the monitored APB bus signals.
// Signals: req_i/write_i/wdata_i  per-requester request, direction, write data
//          grant_o/done_o/rdata_o per-requester grant, done pulse, read data
//          timeout_o              current transfer exceeded its cycle budget
//          add_o/wdata_o          command and write data to the APB master
//          psel_i/penable_i/pready_i/prdata_i  monitored APB bus
// Modports: master = arbiter side, slave = requesters/APB environment side.
interface apb_req_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_i;
  logic [NUM_REQ-1:0]    write_i;
  logic [NUM_REQ*32-1:0] wdata_i;
  logic [NUM_REQ-1:0]    grant_o;
  logic [NUM_REQ-1:0]    done_o;
  logic [31:0]           rdata_o;
  logic                  timeout_o;
  logic [1:0]            add_o;
  logic [31:0]           wdata_o;
  logic                  psel_i;
  logic                  penable_i;
  logic                  pready_i;
  logic [31:0]           prdata_i;

  modport master (
    input  req_i, write_i, wdata_i, psel_i, penable_i, pready_i, prdata_i,
    output grant_o, done_o, rdata_o, timeout_o, add_o, wdata_o
  );

  modport slave (
    output req_i, write_i, wdata_i, psel_i, penable_i, pready_i, prdata_i,
    input  grant_o, done_o, rdata_o, timeout_o, add_o, wdata_o
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - round-robin arbiter sharing one APB master among NUM_REQ requesters
// Purpose: grants one requester at a time, issues a one-cycle command to the
//          APB master, watches the bus for completion and returns done/rdata.
// Ports:   pclk    clock, rising edge
//          preset  synchronous reset, active-high
//          bus     apb_req_arbiter_if.master (requester side + APB command/monitor)
module apb_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic               pclk,
  input logic               preset,
  apb_req_arbiter_if.master bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t              state_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [NUM_REQ-1:0]  done_q;
  logic [31:0]         rdata_q;
  logic                timeout_q;
  logic [1:0]          add_q;
  logic [31:0]         wdata_q;
  logic [IW-1:0]       ptr_q;
  logic [IW-1:0]       idx_q;
  logic                dir_q;
  logic [CW-1:0]       cnt_q;

  logic [IW-1:0]       cand;
  logic [IW-1:0]       pick_idx;
  logic                pick_valid;

  // Round-robin search: first set request starting at the pointer, wrapping.
  always_comb begin
    cand       = '0;
    pick_idx   = ptr_q;
    pick_valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % NUM_REQ);
      if (!pick_valid && bus.req_i[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
      add_q     <= 2'b00;
      wdata_q   <= '0;
      ptr_q     <= '0;
      idx_q     <= '0;
      dir_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_q <= NUM_REQ'(1) << pick_idx;
            idx_q   <= pick_idx;
            dir_q   <= bus.write_i[pick_idx];
            wdata_q <= bus.wdata_i[{pick_idx, 5'b00000} +: 32];
            // Command is registered here so it is visible during ISSUE.
            add_q   <= {bus.write_i[pick_idx], 1'b1};
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          add_q   <= 2'b00;
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (bus.psel_i && bus.penable_i && bus.pready_i) begin
            if (!dir_q) begin
              rdata_q <= bus.prdata_i;
            end
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            done_q    <= grant_q;
            state_q   <= DONE;
          end else if (cnt_q != CW'(TIMEOUT_CYCLES)) begin
            // Flag raised on the edge where the counter reaches the limit;
            // the transfer keeps going because APB cannot abort it.
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
              timeout_q <= 1'b1;
            end
          end
        end
        DONE: begin
          done_q  <= '0;
          grant_q <= '0;
          ptr_q   <= (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant_o   = grant_q;
  assign bus.done_o    = done_q;
  assign bus.rdata_o   = rdata_q;
  assign bus.timeout_o = timeout_q;
  assign bus.add_o     = add_q;
  assign bus.wdata_o   = wdata_q;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb/tb_apb_req_arbiter.sv - self-checking bench for apb_req_arbiter
module tb_apb_req_arbiter;
  localparam int N = 4;
  localparam int T = 8;

  logic pclk = 1'b0;
  logic preset;

  apb_req_arbiter_if #(.NUM_REQ(N)) bus ();

  apb_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  wr;
    int          waits;
    logic [31:0] prdata;
    logic [3:0]  exp_grant;
    logic [1:0]  exp_add;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t         tbl [12];
  logic [127:0] tbl_wd;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // APB master emulation: 0 idle, 1 setup, 2 access
  int          m_phase;
  int          m_wait;
  int          cfg_wait;
  logic [31:0] cfg_prdata;
  logic [1:0]  prev_add;
  logic        force_bus;

  int          model_ptr;
  logic [31:0] model_rdata;

  task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s cyc=%0d actual=%h required=%h", tag, what, cyc, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge pclk);
    #1;
    cyc++;
    if (preset) begin
      m_phase = 0;
      prev_add = 2'b00;
    end else if (m_phase == 2 && bus.pready_i) begin
      m_phase = 0;
    end else if (m_phase == 2) begin
      if (m_wait > 0) m_wait--;
    end else if (m_phase == 1) begin
      m_phase = 2;
      m_wait  = cfg_wait;
    end else if (prev_add != 2'b00) begin
      m_phase = 1;
    end
    if (force_bus) begin
      bus.psel_i = 1'b1; bus.penable_i = 1'b1; bus.pready_i = 1'b1;
    end else begin
      bus.psel_i    = (m_phase != 0);
      bus.penable_i = (m_phase == 2);
      bus.pready_i  = (m_phase == 2) && (m_wait == 0);
    end
    bus.prdata_i = bus.pready_i ? cfg_prdata : $urandom;
    prev_add = preset ? 2'b00 : bus.add_o;
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int p);
    int w;
    w = -1;
    for (int k = N - 1; k >= 0; k--)
      if (r[2'((p + k) % N)]) w = (p + k) % N;
    return w;
  endfunction

  function automatic int onehot_idx(input logic [3:0] g);
    int w;
    w = 0;
    for (int k = 0; k < N; k++) if (g[2'(k)]) w = k;
    return w;
  endfunction

  // Starts in an idle cycle (cycle 0), ends in the first idle cycle after DONE.
  task automatic run_txn(input string tag, input logic [3:0] req, input logic [3:0] wr,
                         input logic [127:0] wd, input int waits, input logic [31:0] prd,
                         input logic [3:0] eg, input logic [1:0] ea, input logic [31:0] ew,
                         input logic [31:0] er, input bit hold);
    bus.req_i = req; bus.write_i = wr; bus.wdata_i = wd;
    cfg_wait = waits; cfg_prdata = prd;
    for (int c = 1; c <= waits + 4; c++) begin
      cycle();
      if (!hold) bus.req_i = 4'($urandom);
      bus.write_i = 4'($urandom);
      bus.wdata_i = {$urandom, $urandom, $urandom, $urandom};
      chk(tag, "grant", 32'(bus.grant_o), 32'(eg));
      chk(tag, "add", 32'(bus.add_o), (c == 1) ? 32'(ea) : 32'd0);
      chk(tag, "done", 32'(bus.done_o), (c == waits + 4) ? 32'(eg) : 32'd0);
      chk(tag, "timeout", 32'(bus.timeout_o), 32'((c >= T + 2) && (c <= waits + 3)));
      chk(tag, "wdata", bus.wdata_o, ew);
      if (c == waits + 4) model_rdata = er;
      chk(tag, "rdata", bus.rdata_o, model_rdata);
    end
    cycle();
    bus.req_i = '0; bus.write_i = '0;
    chk(tag, "idle_grant", 32'(bus.grant_o), 32'd0);
    chk(tag, "idle_done", 32'(bus.done_o), 32'd0);
    model_ptr = (onehot_idx(eg) + 1) % N;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(tag, "grant", 32'(bus.grant_o), 32'd0);
    chk(tag, "done", 32'(bus.done_o), 32'd0);
    chk(tag, "rdata", bus.rdata_o, 32'd0);
    chk(tag, "timeout", 32'(bus.timeout_o), 32'd0);
    chk(tag, "add", 32'(bus.add_o), 32'd0);
    chk(tag, "wdata", bus.wdata_o, 32'd0);
  endtask

  task automatic fill_table();
    tbl_wd = {32'hCAFE0003, 32'h12345678, 32'hCAFE0001, 32'hCAFE0000};
    tbl[0]  = '{4'b0001, 4'b0000, 0,  32'hDEADBEEF, 4'b0001, 2'b01, 32'hCAFE0000, 32'hDEADBEEF};
    tbl[1]  = '{4'b0100, 4'b0100, 0,  32'hFFFFFFFF, 4'b0100, 2'b11, 32'h12345678, 32'hDEADBEEF};
    tbl[2]  = '{4'b1111, 4'b0000, 0,  32'h00000003, 4'b1000, 2'b01, 32'hCAFE0003, 32'h00000003};
    tbl[3]  = '{4'b1111, 4'b1010, 0,  32'h00000004, 4'b0001, 2'b01, 32'hCAFE0000, 32'h00000004};
    tbl[4]  = '{4'b1111, 4'b1010, 0,  32'h00000005, 4'b0010, 2'b11, 32'hCAFE0001, 32'h00000004};
    tbl[5]  = '{4'b1111, 4'b1010, 0,  32'h00000006, 4'b0100, 2'b01, 32'h12345678, 32'h00000006};
    tbl[6]  = '{4'b1111, 4'b1010, 0,  32'h00000007, 4'b1000, 2'b11, 32'hCAFE0003, 32'h00000006};
    tbl[7]  = '{4'b1111, 4'b1010, 0,  32'h00000008, 4'b0001, 2'b01, 32'hCAFE0000, 32'h00000008};
    tbl[8]  = '{4'b0010, 4'b0000, 5,  32'h00005A5A, 4'b0010, 2'b01, 32'hCAFE0001, 32'h00005A5A};
    tbl[9]  = '{4'b1000, 4'b1000, 12, 32'hBADBAD00, 4'b1000, 2'b11, 32'hCAFE0003, 32'h00005A5A};
    tbl[10] = '{4'b0110, 4'b0000, 0,  32'h11112222, 4'b0010, 2'b01, 32'hCAFE0001, 32'h11112222};
    tbl[11] = '{4'b0011, 4'b0000, 0,  32'h33334444, 4'b0001, 2'b01, 32'hCAFE0000, 32'h33334444};
  endtask

  task automatic random_phase();
    int          idle_n, w, waits;
    logic [3:0]  req, wr, eg;
    logic [1:0]  ea;
    logic [127:0] wd;
    logic [31:0] prd, ew, er;
    for (int t = 0; t < 40; t++) begin
      idle_n = $urandom_range(0, 2);
      for (int i = 0; i < idle_n; i++) begin
        force_bus = ($urandom_range(0, 1) == 1);
        cycle();
        chk("rnd_idle", "grant", 32'(bus.grant_o), 32'd0);
        chk("rnd_idle", "add", 32'(bus.add_o), 32'd0);
        chk("rnd_idle", "done", 32'(bus.done_o), 32'd0);
      end
      force_bus = 1'b0;
      req   = 4'($urandom_range(1, 15));
      wr    = 4'($urandom);
      wd    = {$urandom, $urandom, $urandom, $urandom};
      waits = $urandom_range(0, 12);
      prd   = $urandom;
      w     = rr_pick(req, model_ptr);
      eg    = 4'(1 << w);
      ea    = {wr[2'(w)], 1'b1};
      ew    = 32'(wd >> (w * 32));
      er    = wr[2'(w)] ? model_rdata : prd;
      run_txn("rnd", req, wr, wd, waits, prd, eg, ea, ew, er, bit'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    m_phase = 0; m_wait = 0; cfg_wait = 0; cfg_prdata = '0; prev_add = 2'b00;
    force_bus = 1'b0; model_ptr = 0; model_rdata = '0;
    bus.req_i = '0; bus.write_i = '0; bus.wdata_i = '0;
    bus.psel_i = 1'b0; bus.penable_i = 1'b0; bus.pready_i = 1'b0; bus.prdata_i = '0;
    preset = 1'b1;
    cycle();
    cycle();
    check_reset_outputs("reset");
    preset = 1'b0;

    fill_table();
    for (int i = 0; i < 12; i++)
      run_txn($sformatf("tbl%0d", i), tbl[i].req, tbl[i].wr, tbl_wd, tbl[i].waits, tbl[i].prdata,
              tbl[i].exp_grant, tbl[i].exp_add, tbl[i].exp_wdata, tbl[i].exp_rdata, 1'b1);

    // Bus activity outside WAIT must not complete anything.
    force_bus = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bus_idle", "done", 32'(bus.done_o), 32'd0);
      chk("bus_idle", "grant", 32'(bus.grant_o), 32'd0);
    end
    force_bus = 1'b0;
    cycle();
    chk("bus_idle", "done_after", 32'(bus.done_o), 32'd0);
    chk("bus_idle", "rdata", bus.rdata_o, model_rdata);

    // Reset in the middle of WAIT.
    bus.req_i = 4'b0001; bus.write_i = 4'b0000; bus.wdata_i = tbl_wd;
    cfg_wait = 3; cfg_prdata = 32'h0BAD0BAD;
    cycle();
    chk("rst_wait", "grant_c1", 32'(bus.grant_o), 32'h1);
    cycle();
    cycle();
    preset = 1'b1;
    cycle();
    preset = 1'b0;
    bus.req_i = '0;
    check_reset_outputs("rst_wait");
    model_ptr = 0; model_rdata = '0;
    run_txn("rst_new", 4'b0010, 4'b0000, tbl_wd, 0, 32'hA5A55A5A,
            4'b0010, 2'b01, 32'hCAFE0001, 32'hA5A55A5A, 1'b1);

    random_phase();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
